// File: rtl/gat_bram_loader.sv
// gat_bram_loader: takes one word stream and writes it, in order, into three BRAM
// write ports: H data first, then node info, then weights.
//
// Handshake: s_valid/s_ready are strict valid/ready. A word is taken on any rising
// clock edge where s_valid && s_ready. s_ready depends only on the FSM state, never
// on s_valid. Each word taken produces one registered write on the next cycle, with
// ena = wea = 1 and addra = word_index << 2. Between writes, din/addra keep their
// last value and ena/wea stay low.
// Each region depth must be at least 2, so that its counter width is non-zero.
module gat_bram_loader #(
   parameter int TOP_WIDTH       = 32,
   parameter int H_DATA_DEPTH    = 242101,
   parameter int NODE_INFO_DEPTH = 13264,
   parameter int WEIGHT_DEPTH    = 22928,
   localparam int H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH),
   localparam int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
   localparam int WEIGHT_ADDR_W    = $clog2(WEIGHT_DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_start,
   input  logic [TOP_WIDTH-1:0]          s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [TOP_WIDTH-1:0]          h_data_bram_din,
   output logic                          h_data_bram_ena,
   output logic                          h_data_bram_wea,
   output logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra,
   output logic [TOP_WIDTH-1:0]          h_node_info_bram_din,
   output logic                          h_node_info_bram_ena,
   output logic                          h_node_info_bram_wea,
   output logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra,
   output logic [TOP_WIDTH-1:0]          wgt_bram_din,
   output logic                          wgt_bram_ena,
   output logic                          wgt_bram_wea,
   output logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra,
   output logic                          h_data_bram_load_done,
   output logic                          h_node_info_bram_load_done,
   output logic                          wgt_bram_load_done,
   output logic                          loader_busy,
   output logic [2:0]                    state_dbg
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LD_H  = 3'd1,
      LD_NI = 3'd2,
      LD_W  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [H_DATA_ADDR_W-1:0]    H_LAST  = H_DATA_ADDR_W'(H_DATA_DEPTH - 1);
   localparam logic [NODE_INFO_ADDR_W-1:0] NI_LAST = NODE_INFO_ADDR_W'(NODE_INFO_DEPTH - 1);
   localparam logic [WEIGHT_ADDR_W-1:0]    W_LAST  = WEIGHT_ADDR_W'(WEIGHT_DEPTH - 1);
   localparam logic [H_DATA_ADDR_W-1:0]    H_ONE   = H_DATA_ADDR_W'(1);
   localparam logic [NODE_INFO_ADDR_W-1:0] NI_ONE  = NODE_INFO_ADDR_W'(1);
   localparam logic [WEIGHT_ADDR_W-1:0]    W_ONE   = WEIGHT_ADDR_W'(1);

   state_t state, state_nxt;
   logic   start, acc_h, acc_ni, acc_w;
   logic   h_last, ni_last, w_last;

   logic [H_DATA_ADDR_W-1:0]    h_cnt;
   logic [NODE_INFO_ADDR_W-1:0] ni_cnt;
   logic [WEIGHT_ADDR_W-1:0]    w_cnt;

   assign h_last    = (h_cnt == H_LAST);
   assign ni_last   = (ni_cnt == NI_LAST);
   assign w_last    = (w_cnt == W_LAST);
   assign state_dbg = state;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic, handshake and per-region accept strobes.
   // A region hands over on the same edge that takes its last word.
   always_comb begin
      state_nxt   = state;
      s_ready     = 1'b0;
      loader_busy = 1'b0;
      start       = 1'b0;
      acc_h       = 1'b0;
      acc_ni      = 1'b0;
      acc_w       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (load_start) begin
               start     = 1'b1;
               state_nxt = LD_H;
            end
         end
         LD_H: begin
            s_ready     = 1'b1;
            loader_busy = 1'b1;
            acc_h       = s_valid;
            if (s_valid && h_last) state_nxt = LD_NI;
         end
         LD_NI: begin
            s_ready     = 1'b1;
            loader_busy = 1'b1;
            acc_ni      = s_valid;
            if (s_valid && ni_last) state_nxt = LD_W;
         end
         LD_W: begin
            s_ready     = 1'b1;
            loader_busy = 1'b1;
            acc_w       = s_valid;
            if (s_valid && w_last) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // H data write port, word counter and sticky done flag.
   // The counter stops at the last index so that it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt                 <= '0;
         h_data_bram_din       <= '0;
         h_data_bram_addra     <= '0;
         h_data_bram_ena       <= 1'b0;
         h_data_bram_wea       <= 1'b0;
         h_data_bram_load_done <= 1'b0;
      end else begin
         h_data_bram_ena <= 1'b0;
         h_data_bram_wea <= 1'b0;
         if (start) begin
            h_cnt                 <= '0;
            h_data_bram_load_done <= 1'b0;
         end else if (acc_h) begin
            h_data_bram_din   <= s_data;
            h_data_bram_addra <= {h_cnt, 2'b00};
            h_data_bram_ena   <= 1'b1;
            h_data_bram_wea   <= 1'b1;
            if (h_last) h_data_bram_load_done <= 1'b1;
            else        h_cnt                 <= h_cnt + H_ONE;
         end
      end
   end

   // Node-info write port, word counter and sticky done flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ni_cnt                     <= '0;
         h_node_info_bram_din       <= '0;
         h_node_info_bram_addra     <= '0;
         h_node_info_bram_ena       <= 1'b0;
         h_node_info_bram_wea       <= 1'b0;
         h_node_info_bram_load_done <= 1'b0;
      end else begin
         h_node_info_bram_ena <= 1'b0;
         h_node_info_bram_wea <= 1'b0;
         if (start) begin
            ni_cnt                     <= '0;
            h_node_info_bram_load_done <= 1'b0;
         end else if (acc_ni) begin
            h_node_info_bram_din   <= s_data;
            h_node_info_bram_addra <= {ni_cnt, 2'b00};
            h_node_info_bram_ena   <= 1'b1;
            h_node_info_bram_wea   <= 1'b1;
            if (ni_last) h_node_info_bram_load_done <= 1'b1;
            else         ni_cnt                     <= ni_cnt + NI_ONE;
         end
      end
   end

   // Weight write port, word counter and sticky done flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_cnt              <= '0;
         wgt_bram_din       <= '0;
         wgt_bram_addra     <= '0;
         wgt_bram_ena       <= 1'b0;
         wgt_bram_wea       <= 1'b0;
         wgt_bram_load_done <= 1'b0;
      end else begin
         wgt_bram_ena <= 1'b0;
         wgt_bram_wea <= 1'b0;
         if (start) begin
            w_cnt              <= '0;
            wgt_bram_load_done <= 1'b0;
         end else if (acc_w) begin
            wgt_bram_din   <= s_data;
            wgt_bram_addra <= {w_cnt, 2'b00};
            wgt_bram_ena   <= 1'b1;
            wgt_bram_wea   <= 1'b1;
            if (w_last) wgt_bram_load_done <= 1'b1;
            else        w_cnt              <= w_cnt + W_ONE;
         end
      end
   end

endmodule

// File: tb/tb_gat_bram_loader.sv
// Directed bench for gat_bram_loader with small depths (H=4, NI=2, W=3).
// Inputs change on the falling edge and outputs are read on the next falling edge.
module tb_gat_bram_loader;

   localparam int TW = 32;

   logic          clk;
   logic          rst_n;
   logic          load_start;
   logic [TW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [TW-1:0] h_din, ni_din, w_din;
   logic          h_ena, h_wea, ni_ena, ni_wea, w_ena, w_wea;
   logic [3:0]    h_addra;
   logic [2:0]    ni_addra;
   logic [3:0]    w_addra;
   logic          h_done, ni_done, w_done;
   logic          loader_busy;
   logic [2:0]    state_dbg;

   logic [5:0]    en_vec;
   logic [2:0]    flags;
   logic [117:0]  all_out;

   int total = 0;
   int bad   = 0;

   // Expected region (0=H, 1=NI, 2=W), byte address and done flags for words 0..8
   int         reg_t [9] = '{0, 0, 0, 0, 1, 1, 2, 2, 2};
   int         adr_t [9] = '{0, 4, 8, 12, 0, 4, 0, 4, 8};
   logic [2:0] flg_t [9] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100,
                             3'b110, 3'b110, 3'b110, 3'b111};

   assign en_vec  = {h_ena, h_wea, ni_ena, ni_wea, w_ena, w_wea};
   assign flags   = {h_done, ni_done, w_done};
   assign all_out = {s_ready, loader_busy, en_vec, flags, h_din, h_addra,
                     ni_din, ni_addra, w_din, w_addra};

   gat_bram_loader #(
      .TOP_WIDTH(TW), .H_DATA_DEPTH(4), .NODE_INFO_DEPTH(2), .WEIGHT_DEPTH(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .h_data_bram_din(h_din), .h_data_bram_ena(h_ena),
      .h_data_bram_wea(h_wea), .h_data_bram_addra(h_addra),
      .h_node_info_bram_din(ni_din), .h_node_info_bram_ena(ni_ena),
      .h_node_info_bram_wea(ni_wea), .h_node_info_bram_addra(ni_addra),
      .wgt_bram_din(w_din), .wgt_bram_ena(w_ena),
      .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addra),
      .h_data_bram_load_done(h_done), .h_node_info_bram_load_done(ni_done),
      .wgt_bram_load_done(w_done), .loader_busy(loader_busy),
      .state_dbg(state_dbg)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; load_start = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (2) @(negedge clk);
      total++;
      if (all_out !== '0) begin
         bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      total++;
      if (state_dbg !== 3'd0) begin
         bad++; $display("FAIL reset_state: got %0d want 0", state_dbg);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (all_out !== '0) begin
         bad++; $display("FAIL post_reset_idle: got %h want 0", all_out);
      end
   endtask

   task automatic test_idle_valid();
      s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if ({s_ready, en_vec, flags} !== 10'd0) begin
            bad++; $display("FAIL idle_valid[%0d]: got %b want 0", k, {s_ready, en_vec, flags});
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp_en;
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      total++;
      if ({s_ready, loader_busy, flags, state_dbg} !== {2'b11, 3'b000, 3'd1}) begin
         bad++; $display("FAIL b2b_start: got %b want 11000001", {s_ready, loader_busy, flags, state_dbg});
      end
      for (int i = 0; i < 9; i++) begin
         s_valid = 1'b1; s_data = 32'(32'h10 + i);
         @(negedge clk);
         exp_en = (reg_t[i] == 0) ? 6'b110000 : (reg_t[i] == 1) ? 6'b001100 : 6'b000011;
         total++;
         if (en_vec !== exp_en) begin
            bad++; $display("FAIL b2b_en[%0d]: got %b want %b", i, en_vec, exp_en);
         end
         total++;
         case (reg_t[i])
            0: if (h_addra !== 4'(adr_t[i]) || h_din !== 32'(32'h10 + i)) begin
                  bad++; $display("FAIL b2b_h[%0d]: got a=%0d d=%h want a=%0d d=%h", i, h_addra, h_din, adr_t[i], 32'h10 + i);
               end
            1: if (ni_addra !== 3'(adr_t[i]) || ni_din !== 32'(32'h10 + i)) begin
                  bad++; $display("FAIL b2b_ni[%0d]: got a=%0d d=%h want a=%0d d=%h", i, ni_addra, ni_din, adr_t[i], 32'h10 + i);
               end
            default: if (w_addra !== 4'(adr_t[i]) || w_din !== 32'(32'h10 + i)) begin
                  bad++; $display("FAIL b2b_w[%0d]: got a=%0d d=%h want a=%0d d=%h", i, w_addra, w_din, adr_t[i], 32'h10 + i);
               end
         endcase
         total++;
         if ({loader_busy, flags} !== {(i < 8), flg_t[i]}) begin
            bad++; $display("FAIL b2b_flags[%0d]: got %b want %b", i, {loader_busy, flags}, {(i < 8), flg_t[i]});
         end
      end
      s_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({s_ready, loader_busy, en_vec, flags, state_dbg} !== {8'b0, 3'b111, 3'd4}) begin
         bad++; $display("FAIL b2b_done: got %b want 00000000111100", {s_ready, loader_busy, en_vec, flags, state_dbg});
      end
   endtask

   task automatic test_reload_from_done();
      load_start = 1'b1; s_valid = 1'b1; s_data = 32'h99;
      @(negedge clk);
      load_start = 1'b0;
      total++;
      if ({loader_busy, flags, en_vec} !== {1'b1, 9'b0}) begin
         bad++; $display("FAIL reload_clear: got %b want 1000000000", {loader_busy, flags, en_vec});
      end
      s_data = 32'h20;
      @(negedge clk);
      total++;
      if (en_vec !== 6'b110000 || h_addra !== 4'd0 || h_din !== 32'h20) begin
         bad++; $display("FAIL reload_first: got en=%b a=%0d d=%h want en=110000 a=0 d=20", en_vec, h_addra, h_din);
      end
      for (int i = 1; i < 9; i++) begin
         s_data = 32'(32'h20 + i);
         @(negedge clk);
      end
      s_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({loader_busy, flags} !== 4'b0111 || w_addra !== 4'd8 || w_din !== 32'h28) begin
         bad++; $display("FAIL reload_end: got bf=%b a=%0d d=%h want bf=0111 a=8 d=28", {loader_busy, flags}, w_addra, w_din);
      end
   endtask

   task automatic test_valid_toggle();
      logic [TW-1:0] exp_d;
      load_start = 1'b1; s_valid = 1'b0;
      @(negedge clk);
      load_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         s_valid = (k % 2 == 0); s_data = 32'(32'h30 + k);
         @(negedge clk);
         exp_d = (k % 2 == 0) ? 32'(32'h30 + k) : 32'(32'h30 + k - 1);
         total++;
         if (en_vec !== ((k % 2 == 0) ? 6'b110000 : 6'b000000) || h_addra !== 4'((k / 2) * 4)
             || h_din !== exp_d || h_done !== (k >= 6)) begin
            bad++; $display("FAIL toggle[%0d]: got en=%b a=%0d d=%h done=%b want a=%0d d=%h", k, en_vec, h_addra, h_din, h_done, (k / 2) * 4, exp_d);
         end
      end
      total++;
      if (state_dbg !== 3'd2) begin
         bad++; $display("FAIL toggle_state: got %0d want 2", state_dbg);
      end
   endtask

   task automatic test_start_in_ld_ni();
      s_valid = 1'b1; s_data = 32'h40;
      @(negedge clk);
      total++;
      if (en_vec !== 6'b001100 || ni_addra !== 3'd0 || ni_din !== 32'h40) begin
         bad++; $display("FAIL ni_first: got en=%b a=%0d d=%h want en=001100 a=0 d=40", en_vec, ni_addra, ni_din);
      end
      s_valid = 1'b0; load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      total++;
      if ({state_dbg, s_ready, loader_busy, flags, en_vec} !== {3'd2, 2'b11, 3'b100, 6'b0}) begin
         bad++; $display("FAIL ni_ignore_start: got %b want 01011100000000", {state_dbg, s_ready, loader_busy, flags, en_vec});
      end
      s_valid = 1'b1; s_data = 32'h41;
      @(negedge clk);
      total++;
      if (en_vec !== 6'b001100 || ni_addra !== 3'd4 || ni_din !== 32'h41 || flags !== 3'b110) begin
         bad++; $display("FAIL ni_second: got en=%b a=%0d d=%h f=%b want en=001100 a=4 d=41 f=110", en_vec, ni_addra, ni_din, flags);
      end
      for (int i = 0; i < 3; i++) begin
         s_data = 32'(32'h42 + i);
         @(negedge clk);
      end
      total++;
      if (en_vec !== 6'b000011 || w_addra !== 4'd8 || w_din !== 32'h44 || {loader_busy, flags} !== 4'b0111) begin
         bad++; $display("FAIL ni_to_done: got en=%b a=%0d d=%h bf=%b want en=000011 a=8 d=44 bf=0111", en_vec, w_addra, w_din, {loader_busy, flags});
      end
      s_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0; s_valid = 1'b1; s_data = 32'h50;
      @(negedge clk);
      s_data = 32'h51;
      @(negedge clk);
      total++;
      if (h_ena !== 1'b1 || h_addra !== 4'd4) begin
         bad++; $display("FAIL mid_pre: got ena=%b a=%0d want ena=1 a=4", h_ena, h_addra);
      end
      s_data = 32'h52; rst_n = 1'b0;
      #1;
      total++;
      if (all_out !== '0) begin
         bad++; $display("FAIL mid_reset_now: got %h want 0", all_out);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         total++;
         if (all_out !== '0) begin
            bad++; $display("FAIL mid_reset_hold[%0d]: got %h want 0", k, all_out);
         end
      end
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         total++;
         if ({s_ready, loader_busy, en_vec} !== 8'd0) begin
            bad++; $display("FAIL mid_need_start[%0d]: got %b want 0", k, {s_ready, loader_busy, en_vec});
         end
      end
      load_start = 1'b1; s_valid = 1'b0;
      @(negedge clk);
      load_start = 1'b0; s_valid = 1'b1; s_data = 32'h60;
      @(negedge clk);
      total++;
      if (en_vec !== 6'b110000 || h_addra !== 4'd0 || h_din !== 32'h60) begin
         bad++; $display("FAIL mid_restart: got en=%b a=%0d d=%h want en=110000 a=0 d=60", en_vec, h_addra, h_din);
      end
      for (int i = 1; i < 9; i++) begin
         s_data = 32'(32'h60 + i);
         @(negedge clk);
      end
      s_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({loader_busy, flags} !== 4'b0111 || w_din !== 32'h68) begin
         bad++; $display("FAIL mid_end: got bf=%b d=%h want bf=0111 d=68", {loader_busy, flags}, w_din);
      end
   endtask

   // Test sequence and final report
   initial begin
      test_reset();
      test_idle_valid();
      test_back_to_back();
      test_reload_from_done();
      test_valid_toggle();
      test_start_in_ld_ni();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
